// File: rtl/mem_write_checker.sv
// -----------------------------------------------------------------------------
// mem_write_checker
//
// Snoops the data-memory write port of the core and checks every store against
// a runtime-loaded table of expected (address, data) pairs. Entries match
// either strictly in index order (MODE 0) or in any order with each entry
// consumed at most once (MODE 1). Stores inside the ignore window are skipped.
// A terminator store ends the run successfully. Anything else, or a stall
// longer than TIMEOUT cycles, ends the run with a captured failure record.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   cfg_we/idx/addr/data/cnt : table entry write (dropped while busy)
//   cfg_num_we/cfg_num  : number of valid entries (dropped while busy)
//   start               : begin a run (ignored while busy)
//   MemWrite/DataAdr/WriteData : snooped store port
//   busy, done, all_hit, fail, fail_code, fail_addr, fail_data : run status
//   pass_count, hit_count : hits on counted entries / on any entry
//   dbg_state           : current FSM state (0 IDLE, 1 RUN, 2 DONE, 3 FAIL)
//
// Handshake: there is none on the store port; every clock edge in RUN with
// MemWrite high is one store event and is classified in that same cycle.
// -----------------------------------------------------------------------------
module mem_write_checker #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int MODE      = 0,
    parameter int IGN_LO    = 96,
    parameter int IGN_HI    = 99,
    parameter int DONE_ADDR = 40,
    parameter int DONE_DATA = 30,
    parameter int TIMEOUT   = 0,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_cnt,
    input  logic              cfg_num_we,
    input  logic [CW-1:0]     cfg_num,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              busy,
    output logic              done,
    output logic              all_hit,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CW-1:0]     pass_count,
    output logic [CW-1:0]     hit_count,
    output logic [1:0]        dbg_state
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [ADDR_W-1:0] IGN_LO_A  = ADDR_W'(IGN_LO);
    localparam logic [ADDR_W-1:0] IGN_HI_A  = ADDR_W'(IGN_HI);
    localparam logic [ADDR_W-1:0] DONE_A    = ADDR_W'(DONE_ADDR);
    localparam logic [DATA_W-1:0] DONE_D    = DATA_W'(DONE_DATA);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [DEPTH-1:0][ADDR_W-1:0]   tbl_addr_q, tbl_addr_d;
    logic [DEPTH-1:0][DATA_W-1:0]   tbl_data_q, tbl_data_d;
    logic [DEPTH-1:0]               tbl_cnt_q, tbl_cnt_d;
    logic [DEPTH-1:0]               hit_flags_q, hit_flags_d;
    logic [CW-1:0]                  num_q, num_d;
    logic [CW-1:0]                  ptr_q, ptr_d;
    logic [TW-1:0]                  to_q, to_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           all_hit_q, all_hit_d;
    logic                           fail_q, fail_d;
    logic [1:0]                     code_q, code_d;
    logic [ADDR_W-1:0]              faddr_q, faddr_d;
    logic [DATA_W-1:0]              fdata_q, fdata_d;
    logic [CW-1:0]                  pass_q, pass_d;
    logic [CW-1:0]                  hit_q, hit_d;

    logic                           cfg_open;
    logic                           match_found;
    logic [IW-1:0]                  match_idx;
    logic [IW-1:0]                  ptr_idx;

    // ptr only indexes the table while ptr < cfg_num <= DEPTH, so the low
    // IW bits are sufficient for the lookup.
    assign ptr_idx = ptr_q[IW-1:0];

    // Table lookup for the current store.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        if (MODE == 0) begin
            if ((ptr_q < num_q) && (tbl_addr_q[ptr_idx] == DataAdr) &&
                (tbl_data_q[ptr_idx] == WriteData)) begin
                match_found = 1'b1;
                match_idx   = ptr_idx;
            end
        end else begin
            // Scan downwards so the lowest matching index is the last written.
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if ((i < int'(num_q)) && !hit_flags_q[i] &&
                    (tbl_addr_q[i] == DataAdr) && (tbl_data_q[i] == WriteData)) begin
                    match_found = 1'b1;
                    match_idx   = IW'(i);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tbl_addr_d  = tbl_addr_q;
        tbl_data_d  = tbl_data_q;
        tbl_cnt_d   = tbl_cnt_q;
        hit_flags_d = hit_flags_q;
        num_d       = num_q;
        ptr_d       = ptr_q;
        to_d        = to_q;
        done_d      = done_q;
        all_hit_d   = all_hit_q;
        code_d      = code_q;
        faddr_d     = faddr_q;
        fdata_d     = fdata_q;
        pass_d      = pass_q;
        hit_d       = hit_q;

        cfg_open = (state_q != S_RUN);

        if (cfg_open && cfg_we && (int'(cfg_idx) < DEPTH)) begin
            tbl_addr_d[cfg_idx] = cfg_addr;
            tbl_data_d[cfg_idx] = cfg_data;
            tbl_cnt_d[cfg_idx]  = cfg_cnt;
        end
        if (cfg_open && cfg_num_we) begin
            num_d = cfg_num;
        end

        case (state_q)
            S_RUN: begin
                if (MemWrite) begin
                    to_d = '0;
                    if (match_found) begin
                        hit_d = hit_q + CW'(1);
                        if (tbl_cnt_q[match_idx]) begin
                            pass_d = pass_q + CW'(1);
                        end
                        if (MODE == 0) begin
                            ptr_d = ptr_q + CW'(1);
                        end else begin
                            hit_flags_d[match_idx] = 1'b1;
                        end
                    end else if ((DataAdr == DONE_A) && (WriteData == DONE_D)) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        all_hit_d = (hit_q == num_q);
                    end else if ((DataAdr >= IGN_LO_A) && (DataAdr <= IGN_HI_A)) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_FAIL;
                        code_d  = 2'd1;
                        faddr_d = DataAdr;
                        fdata_d = WriteData;
                    end
                end else if (TIMEOUT > 0) begin
                    // Fail on the edge that would bring the idle count to
                    // TIMEOUT, so fail shows exactly TIMEOUT cycles after busy.
                    if (int'(to_q) >= TIMEOUT - 1) begin
                        state_d = S_FAIL;
                        code_d  = 2'd2;
                        faddr_d = '0;
                        fdata_d = '0;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end
            end
            default: begin
                // IDLE, DONE and FAIL all wait for start; stores are ignored.
                if (start) begin
                    state_d     = S_RUN;
                    hit_flags_d = '0;
                    ptr_d       = '0;
                    to_d        = '0;
                    done_d      = 1'b0;
                    all_hit_d   = 1'b0;
                    code_d      = 2'd0;
                    faddr_d     = '0;
                    fdata_d     = '0;
                    pass_d      = '0;
                    hit_d       = '0;
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
        fail_d = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tbl_addr_q  <= '0;
            tbl_data_q  <= '0;
            tbl_cnt_q   <= '0;
            hit_flags_q <= '0;
            num_q       <= '0;
            ptr_q       <= '0;
            to_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            all_hit_q   <= 1'b0;
            fail_q      <= 1'b0;
            code_q      <= 2'd0;
            faddr_q     <= '0;
            fdata_q     <= '0;
            pass_q      <= '0;
            hit_q       <= '0;
        end else begin
            state_q     <= state_d;
            tbl_addr_q  <= tbl_addr_d;
            tbl_data_q  <= tbl_data_d;
            tbl_cnt_q   <= tbl_cnt_d;
            hit_flags_q <= hit_flags_d;
            num_q       <= num_d;
            ptr_q       <= ptr_d;
            to_q        <= to_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            all_hit_q   <= all_hit_d;
            fail_q      <= fail_d;
            code_q      <= code_d;
            faddr_q     <= faddr_d;
            fdata_q     <= fdata_d;
            pass_q      <= pass_d;
            hit_q       <= hit_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign all_hit    = all_hit_q;
    assign fail       = fail_q;
    assign fail_code  = code_q;
    assign fail_addr  = faddr_q;
    assign fail_data  = fdata_q;
    assign pass_count = pass_q;
    assign hit_count  = hit_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// -----------------------------------------------------------------------------
// tb_mem_write_checker
//
// Two checker instances share one stimulus stream: u_m0 is ordered with an
// 8-cycle timeout, u_m1 is any-order without timeout. Each expected record
// names which instance it describes. Inputs change 1 time unit after a rising
// edge and outputs are sampled 1 time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_mem_write_checker;

    localparam int DEPTH = 64;
    localparam int IW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [31:0] N35 = 32'hFFFF_FFDD;   // -35
    localparam logic [31:0] N64 = 32'hFFFF_FFC0;   // -64

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [31:0]   cfg_addr = '0;
    logic [31:0]   cfg_data = '0;
    logic          cfg_cnt = 1'b0;
    logic          cfg_num_we = 1'b0;
    logic [CW-1:0] cfg_num = '0;
    logic          start = 1'b0;
    logic          mem_write = 1'b0;
    logic [31:0]   data_adr = '0;
    logic [31:0]   write_data = '0;

    logic          m0_busy, m0_done, m0_all_hit, m0_fail;
    logic [1:0]    m0_code, m0_st;
    logic [31:0]   m0_faddr, m0_fdata;
    logic [CW-1:0] m0_pass, m0_hit;
    logic          m1_busy, m1_done, m1_all_hit, m1_fail;
    logic [1:0]    m1_code, m1_st;
    logic [31:0]   m1_faddr, m1_fdata;
    logic [CW-1:0] m1_pass, m1_hit;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          all_hit;
        logic          fail;
        logic [1:0]    code;
        logic [31:0]   faddr;
        logic [31:0]   fdata;
        logic [CW-1:0] pass;
        logic [CW-1:0] hit;
        logic [1:0]    st;
    } obs_t;

    typedef struct {
        logic        start;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        sel;
        logic        busy;
        logic        done;
        logic        all_hit;
        logic        fail;
        logic [1:0]  code;
        logic [31:0] faddr;
        logic [31:0] fdata;
        int          pass;
        int          hit;
    } vec_t;

    obs_t o0, o1;
    vec_t vecs[$];
    logic [0:0] exp_q[$];
    int n_checks = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    mem_write_checker #(.MODE(0), .TIMEOUT(8)) u_m0 (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_cnt(cfg_cnt), .cfg_num_we(cfg_num_we), .cfg_num(cfg_num), .start(start),
        .MemWrite(mem_write), .DataAdr(data_adr), .WriteData(write_data),
        .busy(m0_busy), .done(m0_done), .all_hit(m0_all_hit), .fail(m0_fail),
        .fail_code(m0_code), .fail_addr(m0_faddr), .fail_data(m0_fdata),
        .pass_count(m0_pass), .hit_count(m0_hit), .dbg_state(m0_st)
    );

    mem_write_checker #(.MODE(1), .TIMEOUT(0)) u_m1 (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_cnt(cfg_cnt), .cfg_num_we(cfg_num_we), .cfg_num(cfg_num), .start(start),
        .MemWrite(mem_write), .DataAdr(data_adr), .WriteData(write_data),
        .busy(m1_busy), .done(m1_done), .all_hit(m1_all_hit), .fail(m1_fail),
        .fail_code(m1_code), .fail_addr(m1_faddr), .fail_data(m1_fdata),
        .pass_count(m1_pass), .hit_count(m1_hit), .dbg_state(m1_st)
    );

    always_comb begin
        o0 = '{busy: m0_busy, done: m0_done, all_hit: m0_all_hit, fail: m0_fail,
               code: m0_code, faddr: m0_faddr, fdata: m0_fdata, pass: m0_pass,
               hit: m0_hit, st: m0_st};
        o1 = '{busy: m1_busy, done: m1_done, all_hit: m1_all_hit, fail: m1_fail,
               code: m1_code, faddr: m1_faddr, fdata: m1_fdata, pass: m1_pass,
               hit: m1_hit, st: m1_st};
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_entry(input int idx, input logic [31:0] a, input logic [31:0] d,
                             input logic c);
        cfg_we   = 1'b1;
        cfg_idx  = IW'(idx);
        cfg_addr = a;
        cfg_data = d;
        cfg_cnt  = c;
        cycle();
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_n(input int n);
        cfg_num_we = 1'b1;
        cfg_num    = CW'(n);
        cycle();
        cfg_num_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_write  = 1'b1;
        data_adr   = a;
        write_data = d;
        cycle();
        mem_write  = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_obs(input string tag, input obs_t o, input vec_t e);
        chk({tag, ".busy"},       32'(o.busy),    32'(e.busy));
        chk({tag, ".done"},       32'(o.done),    32'(e.done));
        chk({tag, ".all_hit"},    32'(o.all_hit), 32'(e.all_hit));
        chk({tag, ".fail"},       32'(o.fail),    32'(e.fail));
        chk({tag, ".fail_code"},  32'(o.code),    32'(e.code));
        chk({tag, ".fail_addr"},  o.faddr,        e.faddr);
        chk({tag, ".fail_data"},  o.fdata,        e.fdata);
        chk({tag, ".pass_count"}, 32'(o.pass),    32'(e.pass));
        chk({tag, ".hit_count"},  32'(o.hit),     32'(e.hit));
    endtask

    task automatic check_zero(input string tag, input obs_t o);
        chk({tag, ".all_outputs"}, 32'(o.busy) | 32'(o.done) | 32'(o.all_hit) | 32'(o.fail)
                                   | 32'(o.code) | o.faddr | o.fdata | 32'(o.pass)
                                   | 32'(o.hit), 32'd0);
        chk({tag, ".state"}, 32'(o.st), 32'd0);
    endtask

    function automatic vec_t mk(input logic st, input logic we, input logic [31:0] a,
                                input logic [31:0] d, input logic sel, input logic busy,
                                input logic dn, input logic ah, input logic fl,
                                input logic [1:0] code, input logic [31:0] fa,
                                input logic [31:0] fd, input int pass, input int hit);
        vec_t v;
        v.start = st; v.we = we; v.addr = a; v.data = d; v.sel = sel;
        v.busy = busy; v.done = dn; v.all_hit = ah; v.fail = fl; v.code = code;
        v.faddr = fa; v.fdata = fd; v.pass = pass; v.hit = hit;
        return v;
    endfunction

    // ---------------- test ----------------
    initial begin
        obs_t o;

        // Both instances see the same table: (100,25,c) (104,4096,c) (108,4184,c).
        //               st we addr data  sel busy dn ah fl code faddr fdata pass hit
        // any-order run with an ignored store, then the terminator
        vecs.push_back(mk(1, 0,   0,    0, 1, 1, 0, 0, 0, 0,   0,    0, 0, 0));
        vecs.push_back(mk(0, 1, 108, 4184, 1, 1, 0, 0, 0, 0,   0,    0, 1, 1));
        vecs.push_back(mk(0, 1,  96,   77, 1, 1, 0, 0, 0, 0,   0,    0, 1, 1));
        vecs.push_back(mk(0, 1, 100,   25, 1, 1, 0, 0, 0, 0,   0,    0, 2, 2));
        vecs.push_back(mk(0, 1, 104, 4096, 1, 1, 0, 0, 0, 0,   0,    0, 3, 3));
        vecs.push_back(mk(0, 1,  40,   30, 1, 0, 1, 1, 0, 0,   0,    0, 3, 3));
        vecs.push_back(mk(0, 1,  12,    5, 1, 0, 1, 1, 0, 0,   0,    0, 3, 3));
        // ordered: out-of-order store fails, failure is sticky
        vecs.push_back(mk(1, 0,   0,    0, 0, 1, 0, 0, 0, 0,   0,    0, 0, 0));
        vecs.push_back(mk(0, 1, 104, 4096, 0, 0, 0, 0, 1, 1, 104, 4096, 0, 0));
        vecs.push_back(mk(0, 1, 100,   25, 0, 0, 0, 0, 1, 1, 104, 4096, 0, 0));
        // ordered: duplicate of an already consumed entry fails
        vecs.push_back(mk(1, 0,   0,    0, 0, 1, 0, 0, 0, 0,   0,    0, 0, 0));
        vecs.push_back(mk(0, 1, 100,   25, 0, 1, 0, 0, 0, 0,   0,    0, 1, 1));
        vecs.push_back(mk(0, 1,  97,    1, 0, 1, 0, 0, 0, 0,   0,    0, 1, 1));
        vecs.push_back(mk(0, 1, 100,   25, 0, 0, 0, 0, 1, 1, 100,   25, 1, 1));
        // ordered: full in-order pass
        vecs.push_back(mk(1, 0,   0,    0, 0, 1, 0, 0, 0, 0,   0,    0, 0, 0));
        vecs.push_back(mk(0, 1, 100,   25, 0, 1, 0, 0, 0, 0,   0,    0, 1, 1));
        vecs.push_back(mk(0, 1, 104, 4096, 0, 1, 0, 0, 0, 0,   0,    0, 2, 2));
        vecs.push_back(mk(0, 1, 108, 4184, 0, 1, 0, 0, 0, 0,   0,    0, 3, 3));
        vecs.push_back(mk(0, 1,  40,   30, 0, 0, 1, 1, 0, 0,   0,    0, 3, 3));
        // any-order: terminator before all entries hit
        vecs.push_back(mk(1, 0,   0,    0, 1, 1, 0, 0, 0, 0,   0,    0, 0, 0));
        vecs.push_back(mk(0, 1, 100,   25, 1, 1, 0, 0, 0, 0,   0,    0, 1, 1));
        vecs.push_back(mk(0, 1,  40,   30, 1, 0, 1, 0, 0, 0,   0,    0, 1, 1));

        // reset state
        reset = 1'b0;
        cycle();
        cycle();
        check_zero("reset_m0", o0);
        check_zero("reset_m1", o1);
        reset = 1'b1;
        cycle();

        cfg_entry(0, 100, 25, 1'b1);
        cfg_entry(1, 104, 4096, 1'b1);
        cfg_entry(2, 108, 4184, 1'b1);
        cfg_n(3);

        foreach (vecs[i]) begin
            start      = vecs[i].start;
            mem_write  = vecs[i].we;
            data_adr   = vecs[i].addr;
            write_data = vecs[i].data;
            cycle();
            o = vecs[i].sel ? o1 : o0;
            check_obs($sformatf("v%0d", i), o, vecs[i]);
        end
        start     = 1'b0;
        mem_write = 1'b0;

        // negative data, one uncounted entry (any-order)
        cfg_entry(0, 160, N35, 1'b1);
        cfg_entry(1, 164, N64, 1'b0);
        cfg_n(2);
        do_start();
        chk("neg.busy", 32'(m1_busy), 32'd1);
        store(164, N64);
        chk("neg.hit1", 32'(m1_hit), 32'd1);
        chk("neg.pass1", 32'(m1_pass), 32'd0);
        store(160, N35);
        store(40, 30);
        check_obs("neg.end", o1, mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 2));

        // table write during RUN is dropped; repeat of a hit pair fails
        cfg_n(1);
        do_start();
        cfg_entry(0, 160, 999, 1'b1);
        store(160, N35);
        check_obs("drop.hit", o1, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        store(160, N35);
        check_obs("repeat", o1, mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 160, N35, 1, 1));

        // timeout: fail exactly 8 cycles after busy rises
        pulse_reset();
        do_start();
        chk("to.busy", 32'(m0_busy), 32'd1);
        for (int k = 1; k <= 8; k++) exp_q.push_back((k == 8) ? 1'b1 : 1'b0);
        for (int k = 1; k <= 8; k++) begin
            logic [0:0] e;
            cycle();
            e = exp_q.pop_front();
            chk($sformatf("to.fail_c%0d", k), 32'(m0_fail), 32'(e));
        end
        check_obs("to.end", o0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        do_start();
        chk("to.restart_busy", 32'(m0_busy), 32'd1);
        chk("to.restart_fail", 32'(m0_fail), 32'd0);
        chk("to.restart_code", 32'(m0_code), 32'd0);

        // asynchronous reset mid-run clears everything, table included
        pulse_reset();
        cfg_entry(0, 100, 25, 1'b1);
        cfg_n(1);
        do_start();
        store(100, 25);
        check_obs("ar.pre", o1, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        #2;
        reset = 1'b0;
        #1;
        check_zero("ar.async", o1);
        #1;
        reset = 1'b1;
        cycle();
        do_start();
        store(100, 25);
        check_obs("ar.cleared", o1, mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 100, 25, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
